// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave that stands in for the joystick module.
// It returns a 5-byte position/button frame and decodes the master's command
// byte into two LED bits. All SPI pins are oversampled in the clk domain.
module jstk_spi_responder #(
    parameter int SCLK_MIN_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_en,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Ratios below 8 leave miso no settling margin before the next sclk rise;
    // the block itself has no logic that depends on the ratio.
    if (SCLK_MIN_DIV < 8) begin : g_slow_sclk_margin_low
    end

    // Byte order of the joystick read frame; indices past the last byte read 0.
    function automatic logic [7:0] tx_byte(input logic [2:0] idx,
                                           input logic [9:0] x,
                                           input logic [9:0] y,
                                           input logic [2:0] b);
        logic [7:0] v;
        case (idx)
            3'd0:    v = x[7:0];
            3'd1:    v = {6'b000000, x[9:8]};
            3'd2:    v = y[7:0];
            3'd3:    v = {6'b000000, y[9:8]};
            3'd4:    v = {5'b00000, b};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Synchronizer chains: [0],[1] are the 2-FF sync, [2] is the edge-detect delay.
    logic [2:0] ss_sync_q;
    logic [2:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;

    logic ss_lvl_s;
    logic ss_fall_s;
    logic ss_rise_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic mosi_bit_s;

    state_t     state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] cmd_q, cmd_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] byte_cnt_q, byte_cnt_d;
    logic [9:0] x_sh_q, x_sh_d;
    logic [9:0] y_sh_q, y_sh_d;
    logic [2:0] btn_sh_q, btn_sh_d;
    logic [1:0] led_q, led_d;
    logic       frame_done_q, frame_done_d;
    logic       miso_q, miso_d;
    logic       miso_en_q, miso_en_d;
    logic       busy_q, busy_d;

    // Shift the raw SPI pins through their synchronizer chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 3'b000;
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            ss_sync_q   <= {ss_sync_q[1:0], ss};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    // Resetting the chains low means an ss already low at release is never seen
    // as a falling edge, so a frame in progress is not joined.
    assign ss_lvl_s    = ss_sync_q[1];
    assign ss_fall_s   = ss_sync_q[2] & ~ss_sync_q[1];
    assign ss_rise_s   = ~ss_sync_q[2] & ss_sync_q[1];
    assign sclk_rise_s = ~sclk_sync_q[2] & sclk_sync_q[1];
    assign sclk_fall_s = sclk_sync_q[2] & ~sclk_sync_q[1];
    assign mosi_bit_s  = mosi_sync_q[1];

    // Frame FSM: next state, shift registers, counters and registered outputs.
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        cmd_d        = cmd_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        x_sh_d       = x_sh_q;
        y_sh_d       = y_sh_q;
        btn_sh_d     = btn_sh_q;
        led_d        = led_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    x_sh_d     = x_pos;
                    y_sh_d     = y_pos;
                    btn_sh_d   = btn;
                    tx_d       = tx_byte(3'd0, x_pos, y_pos, btn);
                    rx_d       = 8'h00;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // ss release wins over any sclk strobe seen in the same cycle.
                if (ss_rise_s) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise_s) begin
                    rx_d      = {rx_q[6:0], mosi_bit_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == 3'd0) begin
                            cmd_d = rx_d;
                        end else begin
                            cmd_d = cmd_q;
                        end
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd4) begin
                            state_d      = ST_HOLD;
                            frame_done_d = 1'b1;
                            if (cmd_q[7:2] == 6'b100000) begin
                                led_d = cmd_q[1:0];
                            end else begin
                                led_d = led_q;
                            end
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q;
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end else begin
                        tx_d = tx_byte(byte_cnt_q, x_sh_q, y_sh_q, btn_sh_q);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (ss_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        miso_d    = (state_d == ST_SHIFT) ? tx_d[7] : 1'b0;
        miso_en_d = ~ss_lvl_s & (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tx_q         <= 8'h00;
            rx_q         <= 8'h00;
            cmd_q        <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 3'd0;
            x_sh_q       <= 10'd0;
            y_sh_q       <= 10'd0;
            btn_sh_q     <= 3'd0;
            led_q        <= 2'b00;
            frame_done_q <= 1'b0;
            miso_q       <= 1'b0;
            miso_en_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            cmd_q        <= cmd_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            x_sh_q       <= x_sh_d;
            y_sh_q       <= y_sh_d;
            btn_sh_q     <= btn_sh_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
            miso_q       <= miso_d;
            miso_en_q    <= miso_en_d;
            busy_q       <= busy_d;
        end
    end

    assign miso       = miso_q;
    assign miso_en    = miso_en_q;
    assign led        = led_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
